// File: rtl/mbgd_accum_tree.sv
// Lane adder tree feeding a mini-batch accumulator with a valid/ready result port.
// The whole pipeline stalls while a finished result waits for its consumer.
module mbgd_accum_tree #(
  parameter int N       = 8,
  parameter int N_BIT   = 3,
  parameter int DW      = 8,
  parameter int ACC_BIT = 4,
  parameter int SIGNED  = 0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [2*DW*N-1:0]              dot_products,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*DW+N_BIT+ACC_BIT-1:0]  outp,
  output logic [ACC_BIT:0]               out_beats,
  output logic                           out_ovf
);

  localparam int LW = 2 * DW;
  localparam int L  = 1 << N_BIT;
  localparam int SW = LW + N_BIT;
  localparam int AW = SW + ACC_BIT;
  localparam int CW = ACC_BIT + 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(1 << ACC_BIT);

  logic            en;
  logic [LW*L-1:0] lanes_pad;

  // Level 0 registers the extended lanes; level k holds L>>k partial sums.
  // Every level is kept at full tree width, so the per-level growth is implicit.
  logic [SW-1:0]   lvl_q [N_BIT+1][L];
  logic [SW-1:0]   lvl_d [N_BIT+1][L];
  logic [N_BIT:0]  vld_q, vld_d;
  logic [N_BIT:0]  last_q, last_d;

  logic [AW-1:0]   tree_ext, acc_next;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            ovf_q, ovf_d, ovf_next;
  logic            fire;

  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   outp_q, outp_d;
  logic [CW-1:0]   beats_q, beats_d;
  logic            out_ovf_q, out_ovf_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    lanes_pad              = '0;
    lanes_pad[LW*N-1:0]    = dot_products;
    lvl_d                  = lvl_q;
    vld_d                  = vld_q;
    last_d                 = last_q;
    if (flush) begin
      vld_d  = '0;
      last_d = '0;
    end else if (en) begin
      for (int j = 0; j < L; j++) begin
        if (SIGNED != 0) lvl_d[0][j] = SW'($signed(lanes_pad[LW*j +: LW]));
        else             lvl_d[0][j] = SW'(lanes_pad[LW*j +: LW]);
      end
      vld_d[0]  = in_valid;
      last_d[0] = in_last;
      for (int k = 1; k <= N_BIT; k++) begin
        for (int j = 0; j < L; j++) lvl_d[k][j] = '0;
        for (int j = 0; j < (L >> k); j++)
          lvl_d[k][j] = lvl_q[k-1][2*j] + lvl_q[k-1][2*j+1];
        vld_d[k]  = vld_q[k-1];
        last_d[k] = last_q[k-1];
      end
    end
  end

  // The accumulator is always zero at a batch start, so no separate first flag is kept.
  always_comb begin
    if (SIGNED != 0) tree_ext = AW'($signed(lvl_q[N_BIT][0]));
    else             tree_ext = AW'(lvl_q[N_BIT][0]);
    acc_next    = acc_q + tree_ext;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    ovf_next    = ovf_q || (cnt_q == CNT_LIM);
    fire        = en && vld_q[N_BIT];

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    outp_d      = outp_q;
    beats_d     = beats_q;
    out_ovf_d   = out_ovf_q;

    if (flush) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      outp_d      = '0;
      beats_d     = '0;
      out_ovf_d   = 1'b0;
    end else begin
      if (en) out_valid_d = 1'b0;
      if (fire) begin
        if (last_q[N_BIT]) begin
          outp_d      = acc_next;
          beats_d     = cnt_inc;
          out_ovf_d   = ovf_next;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          ovf_d = ovf_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      lvl_q       <= '{default: '0};
      vld_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      outp_q      <= '0;
      beats_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      outp_q      <= outp_d;
      beats_q     <= beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outp      = outp_q;
  assign out_beats = beats_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mbgd_accum_tree.sv
// Drives an unsigned and a signed instance with identical beats and checks every
// delivered batch result against a lane-sum scoreboard.
module tb_mbgd_accum_tree;

  localparam int OW = 23;
  localparam longint MASK = (longint'(1) << OW) - 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [127:0] dot_products = '0;
  logic         out_ready = 1'b1;

  logic          ir_u, ir_s, ov_u, ov_s, ovf_u, ovf_s;
  logic [OW-1:0] outp_u, outp_s;
  logic [4:0]    beats_u, beats_s;

  bit rdy_mode = 1'b0;
  bit rdy_fixed = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint u;
    longint s;
    int     beats;
    bit     ovf;
  } res_t;

  res_t   exp_q[$];
  longint part_u = 0;
  longint part_s = 0;
  int     part_n = 0;

  mbgd_accum_tree #(.SIGNED(0)) dut_u (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir_u),
    .in_last(in_last), .dot_products(dot_products), .out_valid(ov_u), .out_ready(out_ready),
    .outp(outp_u), .out_beats(beats_u), .out_ovf(ovf_u));

  mbgd_accum_tree #(.SIGNED(1)) dut_s (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
    .in_last(in_last), .dot_products(dot_products), .out_valid(ov_s), .out_ready(out_ready),
    .outp(outp_s), .out_beats(beats_s), .out_ovf(ovf_s));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [127:0] dp, input bit sgn);
    longint s = 0;
    longint v;
    for (int i = 0; i < 8; i++) begin
      v = {48'd0, dp[16*i +: 16]};
      if (sgn && v >= 32768) v = v - 65536;
      s += v;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand_dp();
    logic [127:0] dp;
    int mode = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) begin
      if (mode == 0)      dp[16*i +: 16] = 16'hFFFF;
      else if (mode == 1) dp[16*i +: 16] = 16'h8000;
      else                dp[16*i +: 16] = 16'($urandom);
    end
    return dp;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Scoreboard: sampled mid-cycle, describing what the next rising edge will do.
  always @(negedge clk) begin
    if (resetn) begin
      exp_q.delete();
      part_u = 0; part_s = 0; part_n = 0;
    end else begin
      check_eq("valid_match", ov_s, ov_u);
      check_eq("in_ready", {ir_u, ir_s}, {2{!ov_u || out_ready}});
      if (ov_u) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", ov_u, 1'b0);
        end else begin
          check_eq("outp_u", outp_u, exp_q[0].u & MASK);
          check_eq("outp_s", outp_s, exp_q[0].s & MASK);
          check_eq("beats", {beats_u, beats_s}, {5'(exp_q[0].beats), 5'(exp_q[0].beats)});
          check_eq("ovf", {ovf_u, ovf_s}, {exp_q[0].ovf, exp_q[0].ovf});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete();
        part_u = 0; part_s = 0; part_n = 0;
      end else if (in_valid && ir_u) begin
        res_t e;
        part_u += lane_sum(dot_products, 1'b0);
        part_s += lane_sum(dot_products, 1'b1);
        part_n++;
        if (in_last) begin
          e.u = part_u;
          e.s = part_s;
          e.beats = (part_n > 31) ? 31 : part_n;
          e.ovf = (part_n > 16);
          exp_q.push_back(e);
          part_u = 0; part_s = 0; part_n = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [127:0] dp, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    dot_products = dp;
    in_last = last;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      ok = ir_u;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_eq("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      done = (exp_q.size() == 0) && !ov_u;
      if (done) break;
      idle(1);
    end
    check_eq({tag, "_drain"}, done, 1'b1);
  endtask

  function automatic logic [127:0] fill_dp(input logic [15:0] even, input logic [15:0] odd);
    logic [127:0] dp;
    for (int i = 0; i < 8; i++) dp[16*i +: 16] = (i % 2 == 0) ? even : odd;
    return dp;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] seq_dp;
    for (int i = 0; i < 8; i++) seq_dp[16*i +: 16] = 16'(i + 1);

    idle(3);
    check_eq("rst_outp", {outp_u, outp_s}, '0);
    check_eq("rst_beats_ovf", {beats_u, ovf_u, beats_s, ovf_s}, '0);
    check_eq("rst_valid", {ov_u, ov_s}, 2'b00);
    check_eq("rst_in_ready", {ir_u, ir_s}, 2'b11);
    resetn = 1'b0;
    idle(2);

    // single beat, every lane at maximum; also measures latency
    send_beat({8{16'hFFFF}}, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (ov_u) begin
        lat = i;
        break;
      end
    end
    check_eq("latency", lat, 4);
    check_eq("max_beat_outp", outp_u, 23'h7FFF8);
    wait_drain("t1");

    // four beats of 1..8 with bubbles in the middle
    send_beat(seq_dp, 1'b0);
    send_beat(seq_dp, 1'b0);
    idle(3);
    send_beat(seq_dp, 1'b0);
    send_beat(seq_dp, 1'b1);
    wait_drain("t2");

    // signed corner patterns
    send_beat(fill_dp(16'hFFFF, 16'h0002), 1'b1);
    send_beat(fill_dp(16'h8000, 16'h8000), 1'b1);
    wait_drain("t3");

    // two batches stream in while the consumer stalls
    rdy_fixed = 1'b0;
    idle(1);
    send_beat(rand_dp(), 1'b0);
    send_beat(rand_dp(), 1'b1);
    send_beat(rand_dp(), 1'b0);
    send_beat(rand_dp(), 1'b1);
    idle(12);
    check_eq("stall_in_ready", ir_u, 1'b0);
    rdy_fixed = 1'b1;
    wait_drain("t4");

    // 17-beat batch overflows the beat headroom; the next batch is clean
    for (int b = 0; b < 17; b++) send_beat(128'd1, b == 16);
    send_beat(128'd5, 1'b0);
    send_beat(128'd7, 1'b1);
    wait_drain("t5");

    // reset mid-batch
    send_beat(seq_dp, 1'b0);
    send_beat(seq_dp, 1'b0);
    resetn = 1'b1;
    idle(2);
    resetn = 1'b0;
    idle(1);
    send_beat(fill_dp(16'h0003, 16'h0000), 1'b1);
    wait_drain("t6a");

    // flush mid-batch; the beat offered during flush is dropped
    send_beat(seq_dp, 1'b0);
    send_beat(seq_dp, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_last = 1'b1;
    dot_products = rand_dp();
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    check_eq("flush_in_ready", ir_u, 1'b1);
    send_beat(fill_dp(16'h0010, 16'h0001), 1'b1);
    wait_drain("t6b");

    // random batches with random backpressure and bubbles
    rdy_mode = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        send_beat(rand_dp(), b == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rdy_mode = 1'b0;
    rdy_fixed = 1'b1;
    idle(2);
    wait_drain("t7");
    check_eq("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
